ifetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined miniRV core. It owns the PC register, drives the instruction-ROM address and latches the fetched word plus its PC into the IF/ID pipeline register. The ID-stage instruction decoder consumes that register. The block applies stall requests from the hazard unit and PC redirects from EX (taken branch, `jal`, `jalr`), squashing the wrong-path fetch with a NOP bubble.

---
 rtl/ifetch_stage.sv | 104 ++++++++++
 tb/tb_ifetch_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_stage
// Purpose  : miniRV instruction fetch. Owns the PC and the IF/ID register,
//            applies hazard stalls and EX-stage redirects.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  output logic [31:0] irom_pc,
  input  logic [31:0] irom_inst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    id_inst_d   = id_inst_q;
    id_pc_d     = id_pc_q;
    id_pc4_d    = id_pc4_q;
    id_valid_d  = id_valid_q;
    fetch_cnt_d = fetch_cnt_q;
    case (state_q)
      BOOT: begin
        state_d    = RUN;
        pc_d       = RESET_PC;
        id_inst_d  = NOP_INST;
        id_valid_d = 1'b0;
      end
      RUN: begin
        if (redirect) begin
          // Wrong-path word is dropped; id_pc/id_pc4 keep their last values.
          pc_d       = {redirect_pc[31:2], 2'b00};
          id_inst_d  = NOP_INST;
          id_valid_d = 1'b0;
        end else if (!stall) begin
          pc_d        = pc_plus4;
          id_inst_d   = irom_inst;
          id_pc_d     = pc_q;
          id_pc4_d    = pc_plus4;
          id_valid_d  = 1'b1;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      id_inst_q   <= NOP_INST;
      id_pc_q     <= 32'h0;
      id_pc4_q    <= 32'h0;
      id_valid_q  <= 1'b0;
      fetch_cnt_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_inst_q   <= id_inst_d;
      id_pc_q     <= id_pc_d;
      id_pc4_q    <= id_pc4_d;
      id_valid_q  <= id_valid_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign irom_pc   = pc_q;
  assign id_inst   = id_inst_q;
  assign id_pc     = id_pc_q;
  assign id_pc4    = id_pc4_q;
  assign id_valid  = id_valid_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_stage
// Purpose  : directed + random fetch-stage bench against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        cpu_clk;
  logic        cpu_rst;
  logic [31:0] irom_pc;
  logic [31:0] irom_inst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic [31:0] fetch_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic        m_boot;
  logic [31:0] m_pc, m_inst, m_idpc, m_idpc4, m_cnt;
  logic        m_valid;

  ifetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .irom_pc    (irom_pc),
    .irom_inst  (irom_inst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .id_pc4     (id_pc4),
    .id_valid   (id_valid),
    .fetch_cnt  (fetch_cnt)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  assign irom_inst = rom(irom_pc);

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".irom_pc"},   irom_pc,         m_pc);
    chk({tag, ".id_inst"},   id_inst,         m_inst);
    chk({tag, ".id_pc"},     id_pc,           m_idpc);
    chk({tag, ".id_pc4"},    id_pc4,          m_idpc4);
    chk({tag, ".id_valid"},  {31'h0, id_valid}, {31'h0, m_valid});
    chk({tag, ".fetch_cnt"}, fetch_cnt,       m_cnt);
  endtask

  task automatic model_reset();
    m_boot  = 1'b1;
    m_pc    = RESET_PC;
    m_inst  = NOP_INST;
    m_idpc  = 32'h0;
    m_idpc4 = 32'h0;
    m_valid = 1'b0;
    m_cnt   = 32'h0;
  endtask

  // Advance the model by one edge using the currently driven inputs.
  task automatic do_edge(input string tag);
    if (m_boot) begin
      m_boot  = 1'b0;
      m_pc    = RESET_PC;
      m_inst  = NOP_INST;
      m_valid = 1'b0;
    end else if (redirect) begin
      m_pc    = redirect_pc & 32'hFFFF_FFFC;
      m_inst  = NOP_INST;
      m_valid = 1'b0;
    end else if (!stall) begin
      m_inst  = rom(m_pc);
      m_idpc  = m_pc;
      m_idpc4 = m_pc + 32'd4;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
      m_pc    = m_pc + 32'd4;
    end
    @(posedge cpu_clk);
    #1;
    check_all(tag);
  endtask

  task automatic step(input string tag, input logic s, input logic r, input logic [31:0] rp);
    @(negedge cpu_clk);
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    do_edge(tag);
  endtask

  // Async reset pulsed between edges; the boot edge that follows is checked too.
  task automatic async_reset(input string tag);
    @(negedge cpu_clk);
    stall    = 1'b0;
    redirect = 1'b0;
    #1 cpu_rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".in_reset"});
    #1 cpu_rst = 1'b0;
    do_edge({tag, ".boot1"});
  endtask

  initial begin
    cpu_rst     = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    model_reset();
    repeat (2) @(posedge cpu_clk);
    #1;
    check_all("reset");
    chk("reset.id_inst_nop", id_inst, 32'h0000_0013);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;

    // Boot: edge 1 is bubble, edge 2 delivers word at RESET_PC
    do_edge("boot1");
    chk("boot1.valid", {31'h0, id_valid}, 32'h0);
    step("boot2", 1'b0, 1'b0, 32'h0);
    chk("boot2.id_inst", id_inst, 32'hA000_0000);
    chk("boot2.id_pc4", id_pc4, 32'h4);
    chk("boot2.cnt", fetch_cnt, 32'h1);

    for (int i = 0; i < 3; i++) step("seq", 1'b0, 1'b0, 32'h0);
    chk("seq.id_pc", id_pc, 32'hC);
    chk("seq.cnt", fetch_cnt, 32'h4);
    chk("seq.irom_pc", irom_pc, 32'h10);

    // Stall while irom_pc=8; redirect also required stall-ignoring
    step("redir8", 1'b0, 1'b1, 32'h8);
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 32'h0);
    chk("stall.irom_pc", irom_pc, 32'h8);
    step("unstall", 1'b0, 1'b0, 32'h0);
    chk("unstall.id_pc", id_pc, 32'h8);

    step("redir_stall", 1'b1, 1'b1, 32'h0000_0103);
    chk("redir_stall.irom_pc", irom_pc, 32'h100);
    chk("redir_stall.id_inst", id_inst, 32'h13);
    chk("redir_stall.cnt", fetch_cnt, 32'h5);
    step("after_redir", 1'b0, 1'b0, 32'h0);
    chk("after_redir.id_pc", id_pc, 32'h100);

    step("wrap_redir", 1'b0, 1'b1, 32'hFFFF_FFFE);
    step("wrap_adv", 1'b0, 1'b0, 32'h0);
    chk("wrap.irom_pc", irom_pc, 32'h0);
    chk("wrap.id_pc4", id_pc4, 32'h0);

    for (int i = 0; i < 6; i++) step("pre_rst", 1'b0, 1'b0, 32'h0);
    async_reset("midrst");
    step("midrst.boot2", 1'b0, 1'b0, 32'h0);
    chk("midrst.boot2.id_inst", id_inst, 32'hA000_0000);

    for (int i = 0; i < 300; i++) begin
      logic s, r;
      logic [31:0] rp;
      s  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 9) == 0);
      rp = $urandom;
      if (i == 150) async_reset("rand_rst");
      else step("rand", s, r, rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
